mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port and data (lw/sw) port. This is needed for the multi-cycle/unified-memory variant of cpu_top, which replaces the separate imem and dmem.
- Each port uses a req/done handshake. Conflicts are arbitrated by alternating priority.
- The memory side issues a one-cycle enable and has a fixed, parameterised read latency.
- A saturating counter records arbitration conflicts for performance analysis.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from m_en to valid m_rdata. Legal range is 1..15.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch request; held high until i_done.
- i_addr  in  ADDR_W  fetch byte address.
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse: access complete, d_rdata valid for loads.
- d_rdata  out  DATA_W  load data.
- m_en  out  1  memory access strobe, exactly one cycle per transaction.
- m_we  out  1  memory write enable; valid only with m_en.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_en.
- busy  out  1  high whenever the FSM is not in IDLE.
- conflict_cnt  out  CNT_W  saturating count of cycles where both requests were seen in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; prio=0 (data preferred).
  - All outputs are 0: m_en, m_we, m_addr, m_wdata, i_done, d_done, i_rdata, d_rdata, busy, conflict_cnt.
  - The latency counter is cleared.
  - A transaction in flight is abandoned with no done pulse; requesters reissue after reset.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples i_req and d_req.
  - Neither high: stay in IDLE.
  - Exactly one high: grant that port; prio is unchanged.
  - Both high: grant the port selected by prio (0 = data, 1 = instruction); then set prio to point at the losing port; conflict_cnt increments, saturating at all-ones.
  - On any grant, latch owner, address, write enable and write data (the fetch port's we is forced to 0), then go to ISSUE.
- ISSUE: 1 cycle.
  - m_en=1; m_we, m_addr and m_wdata driven from the latched values.
  - Latency counter loaded with MEM_LAT; next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter equals 1, m_rdata is registered into the owner's rdata register (loads and fetches only); next state is DONE.
  - Total time in WAIT is exactly MEM_LAT cycles.
- DONE: 1 cycle.
  - Owner's done=1; next state is IDLE.
  - Stores leave d_rdata unchanged.
- Timing:
  - Request first seen in IDLE in cycle 0 gives ISSUE in cycle 1, WAIT in cycles 2..MEM_LAT+1, and done in cycle MEM_LAT+2.
  - Minimum round trip is 3 cycles (MEM_LAT=1).
- rdata registers:
  - i_rdata and d_rdata hold their last value until the next completed read on that port.
  - This lets cpu_top latch them at any time after done.
- Handshake rules:
  - A requester deasserts req in the cycle after done. The FSM is back in IDLE in that cycle, so the old request is never re-granted.
  - A requester that keeps req high past that cycle issues a new transaction.
  - req and inputs are ignored outside IDLE; the latched copy is used.
- busy is a registered decode of state != IDLE.
- m_en is never asserted outside ISSUE, and never asserted twice per transaction.
- A losing requester waits in IDLE-sampled order. Alternating prio bounds its wait to one transaction under continuous contention.

Test Plan:
- Reset mid-WAIT:
  - Start a fetch, pull rst low during WAIT.
  - Required: all outputs 0 immediately, no i_done, busy=0.
  - After release, a new fetch completes normally.
- Single fetch, MEM_LAT=2:
  - Memory model holds 0x00a00093 at 0x40; i_req=1, i_addr=0x40 in cycle 0.
  - Required: m_en=1 only in cycle 1 with m_addr=0x40 and m_we=0; i_done=1 only in cycle 4; i_rdata=0x00a00093.
- Store then load, MEM_LAT=1:
  - d_we=1, d_addr=0x0, d_wdata=0x0000000D.
  - Required: m_we=1 with m_en in cycle 1; d_done in cycle 3.
  - A following load from 0x0 returns d_rdata=0x0000000D.
- Conflict alternation:
  - i_req and d_req held continuously from reset.
  - Required: grants in order data, instr, data, instr.
  - conflict_cnt increments by 1 at each such grant, and m_en pulses are never adjacent.
- Saturation, CNT_W=2:
  - Run 5 conflicts.
  - Required: conflict_cnt reads 3 after the third conflict and stays 3.
- Request hold:
  - d_req left high for 2 cycles after d_done.
  - Required: a second data transaction starts with m_en in the cycle after re-entering IDLE, and d_rdata is updated only at the second d_done.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port unified memory between the CPU instruction-fetch
//   port and the data (lw/sw) port. Each requester uses a req/done handshake.
//   When both ports ask at once, the arbiter alternates priority between them.
//   The memory side receives a one-cycle enable and returns read data a fixed
//   MEM_LAT cycles later. A saturating counter records arbitration conflicts.
//
//   Handshake: a requester raises req with its address/data stable and holds
//   it until done. done is a one-cycle pulse, and rdata is valid from that
//   cycle on. The requester drops req in the next cycle, which is an IDLE
//   cycle. If req is still high then, it is taken as a new transaction.
//   req and the request inputs are only sampled in IDLE.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_req/i_addr        fetch request in; i_done/i_rdata out
//   d_req/d_we/d_addr/d_wdata   data request in; d_done/d_rdata out
//   m_en/m_we/m_addr/m_wdata    memory strobe and command out; m_rdata in
//   busy                high whenever the FSM is outside IDLE
//   conflict_cnt        saturating count of IDLE cycles with both requests
//   dbg_state           current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1,   // legal range 1..15
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy,
   output logic [CNT_W-1:0]  conflict_cnt,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // The latency counter is 4 bits wide, which covers MEM_LAT up to 15.
   localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;     // 1 = instruction port owns the transaction
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              prio_q, prio_d;       // 0 = data preferred, 1 = instruction preferred
   logic [3:0]        lat_q, lat_d;
   logic [CNT_W-1:0]  conflict_q, conflict_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              busy_q, busy_d;
   logic              grant_instr;

   // Next-state and datapath logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      prio_d      = prio_q;
      lat_d       = lat_q;
      conflict_d  = conflict_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_instr = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               // A lone request wins outright. A contested grant goes to prio.
               grant_instr = i_req && (!d_req || prio_q);
               if (i_req && d_req) begin
                  // Point prio at the loser so it wins the next contest.
                  prio_d     = !grant_instr;
                  conflict_d = (&conflict_q) ? conflict_q : conflict_q + CNT_W'(1);
               end
               owner_d = grant_instr;
               addr_d  = grant_instr ? i_addr : d_addr;
               we_d    = !grant_instr && d_we;
               wdata_d = grant_instr ? '0 : d_wdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            lat_d   = LAT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            lat_d = lat_q - 4'd1;
            // When the count reaches 1, m_rdata is exactly MEM_LAT cycles past m_en.
            if (lat_q == 4'd1) begin
               state_d = S_DONE;
               if (!we_q) begin
                  if (owner_q) i_rdata_d = m_rdata;
                  else         d_rdata_d = m_rdata;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy is registered from the next state so it lines up with state_q.
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         prio_q     <= 1'b0;
         lat_q      <= 4'd0;
         conflict_q <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         prio_q     <= prio_d;
         lat_q      <= lat_d;
         conflict_q <= conflict_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
         busy_q     <= busy_d;
      end
   end

   // The memory command is held in registers. m_en is a pure decode of ISSUE,
   // so it lasts one cycle per transaction.
   assign m_en         = (state_q == S_ISSUE);
   assign m_we         = m_en && we_q;
   assign m_addr       = addr_q;
   assign m_wdata      = wdata_q;
   assign i_done       = (state_q == S_DONE) && owner_q;
   assign d_done       = (state_q == S_DONE) && !owner_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign busy         = busy_q;
   assign conflict_cnt = conflict_q;
   assign dbg_state    = state_q;

endmodule
